// File: rtl/mult_error_profiler_if.sv
// Bus between the error profiler and the multiplier under test / host.
// slave: profiler side; master: host and multiplier-under-test side.
interface mult_error_profiler_if #(
    parameter int unsigned N = 4
);
    logic             start;
    logic [N-1:0]     op_a;
    logic [N-1:0]     op_b;
    logic [2*N-1:0]   dut_p;
    logic             busy;
    logic             done;
    logic [2*N:0]     err_count;
    logic [4*N-1:0]   sum_abs_err;
    logic [4*N:0]     sum_signed_err;
    logic [2*N-1:0]   max_abs_err;

    modport slave (
        input  start, dut_p,
        output op_a, op_b, busy, done, err_count, sum_abs_err, sum_signed_err, max_abs_err
    );

    modport master (
        output start, dut_p,
        input  op_a, op_b, busy, done, err_count, sum_abs_err, sum_signed_err, max_abs_err
    );
endinterface

// File: rtl/mult_error_profiler.sv
// Exhaustive error profiler for an NxN approximate multiplier.
// Define PROFILER_PIPE_EN to register dut_p and the exact product before comparison.
module mult_error_profiler #(
    parameter int unsigned N = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    mult_error_profiler_if.slave bus
);
    localparam int unsigned PW = 2 * N;
    localparam logic [PW-1:0] IdxLast = '1;

    typedef enum logic [1:0] {StIdle, StSweep, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   idx_q, idx_d;
    logic [PW:0]     err_count_q, err_count_d;
    logic [4*N-1:0]  sum_abs_q, sum_abs_d;
    logic [4*N:0]    sum_signed_q, sum_signed_d;
    logic [PW-1:0]   max_abs_q, max_abs_d;

    logic [PW-1:0]   a_ext, b_ext, exact_now;
    logic [PW-1:0]   cmp_p, cmp_exact;
    logic            cmp_valid;
    logic [PW:0]     diff, neg_diff;
    logic [PW-1:0]   abs_diff;

    assign a_ext     = PW'(idx_q[PW-1:N]);
    assign b_ext     = PW'(idx_q[N-1:0]);
    assign exact_now = a_ext * b_ext;

`ifdef PROFILER_PIPE_EN
    logic [PW-1:0] p_q, exact_q;
    logic          valid_q;

    // One-stage sample: the pair driven in cycle k is compared in cycle k+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q     <= '0;
            exact_q <= '0;
            valid_q <= 1'b0;
        end else begin
            p_q     <= bus.dut_p;
            exact_q <= exact_now;
            valid_q <= (state_q == StSweep);
        end
    end

    assign cmp_p     = p_q;
    assign cmp_exact = exact_q;
    assign cmp_valid = valid_q;
`else
    assign cmp_p     = bus.dut_p;
    assign cmp_exact = exact_now;
    assign cmp_valid = (state_q == StSweep);
`endif

    assign diff     = {1'b0, cmp_p} - {1'b0, cmp_exact};
    assign neg_diff = -diff;
    assign abs_diff = diff[PW] ? neg_diff[PW-1:0] : diff[PW-1:0];

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        err_count_d  = err_count_q;
        sum_abs_d    = sum_abs_q;
        sum_signed_d = sum_signed_q;
        max_abs_d    = max_abs_q;

        if (cmp_valid) begin
            if (diff != '0) err_count_d = err_count_q + 1'b1;
            sum_abs_d    = sum_abs_q + {{PW{1'b0}}, abs_diff};
            sum_signed_d = sum_signed_q + {{PW{diff[PW]}}, diff};
            if (abs_diff > max_abs_q) max_abs_d = abs_diff;
        end

        case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d      = StSweep;
                    idx_d        = '0;
                    err_count_d  = '0;
                    sum_abs_d    = '0;
                    sum_signed_d = '0;
                    max_abs_d    = '0;
                end
            end
            StSweep: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == IdxLast) begin
`ifdef PROFILER_PIPE_EN
                    state_d = StDrain;
`else
                    state_d = StDone;
`endif
                end
            end
            StDrain: state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            err_count_q  <= '0;
            sum_abs_q    <= '0;
            sum_signed_q <= '0;
            max_abs_q    <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            err_count_q  <= err_count_d;
            sum_abs_q    <= sum_abs_d;
            sum_signed_q <= sum_signed_d;
            max_abs_q    <= max_abs_d;
        end
    end

    assign bus.op_a           = idx_q[PW-1:N];
    assign bus.op_b           = idx_q[N-1:0];
    assign bus.busy           = (state_q == StSweep) || (state_q == StDrain);
    assign bus.done           = (state_q == StDone);
    assign bus.err_count      = err_count_q;
    assign bus.sum_abs_err    = sum_abs_q;
    assign bus.sum_signed_err = sum_signed_q;
    assign bus.max_abs_err    = max_abs_q;
endmodule

// File: tb/tb_mult_error_profiler.sv
// Bench for mult_error_profiler: exact, stuck-zero and LSB-flip multipliers, restart and reset.
module tb_mult_error_profiler;
    localparam int N  = 4;
    localparam int NP = 256;
`ifdef PROFILER_PIPE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif
    localparam int LAT = NP + PIPE;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_error_profiler_if #(.N(N)) bus ();
    mult_error_profiler #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Multiplier under test: 0 exact, 1 stuck-zero, 2 LSB flipped.
    int mode = 0;
    logic [7:0] exact_tb;
    assign exact_tb = {4'b0, bus.op_a} * {4'b0, bus.op_b};
    always_comb begin
        case (mode)
            1:       bus.dut_p = 8'd0;
            2:       bus.dut_p = exact_tb ^ 8'd1;
            default: bus.dut_p = exact_tb;
        endcase
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 30) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Prefix results per mode: value after the first m pairs in sweep order.
    longint p_cnt[3][NP+1];
    longint p_abs[3][NP+1];
    longint p_sig[3][NP+1];
    longint p_max[3][NP+1];

    task automatic build_model();
        for (int md = 0; md < 3; md++) begin
            p_cnt[md][0] = 0; p_abs[md][0] = 0; p_sig[md][0] = 0; p_max[md][0] = 0;
            for (int k = 0; k < NP; k++) begin
                longint e, p, d, ad;
                e = longint'((k / 16) * (k % 16));
                p = (md == 0) ? e : (md == 1) ? 0 : (e ^ 1);
                d = p - e;
                ad = (d < 0) ? -d : d;
                p_cnt[md][k+1] = p_cnt[md][k] + ((d != 0) ? 1 : 0);
                p_abs[md][k+1] = p_abs[md][k] + ad;
                p_sig[md][k+1] = p_sig[md][k] + d;
                p_max[md][k+1] = (ad > p_max[md][k]) ? ad : p_max[md][k];
            end
        end
    endtask

    // Protocol model: a start is accepted only when not busy; c counts cycles since acceptance.
    logic m_run;
    int   m_c;
    int   run_mode;
    logic m_busy;
    assign m_busy = m_run && (m_c < LAT);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run    <= 1'b0;
            m_c      <= 0;
            run_mode <= 0;
        end else if (bus.start && !m_busy) begin
            m_run    <= 1'b1;
            m_c      <= 0;
            run_mode <= mode;
        end else if (m_busy) begin
            m_c <= m_c + 1;
        end
    end

    always @(negedge clk) begin
        int m, pair;
        logic exp_done;
        exp_done = m_run && (m_c >= LAT);
        pair = (m_run && m_c < NP) ? m_c : 0;
        if (!m_run)        m = 0;
        else if (PIPE)     m = (m_c == 0) ? 0 : ((m_c - 1 < NP) ? m_c - 1 : NP);
        else               m = (m_c < NP) ? m_c : NP;
        check("busy", longint'(bus.busy), longint'(m_busy));
        check("done", longint'(bus.done), longint'(exp_done));
        check("op_a", longint'(bus.op_a), longint'(pair / 16));
        check("op_b", longint'(bus.op_b), longint'(pair % 16));
        check("err_count", longint'(bus.err_count), p_cnt[run_mode][m]);
        check("sum_abs_err", longint'(bus.sum_abs_err), p_abs[run_mode][m]);
        check("sum_signed_err", longint'($signed(bus.sum_signed_err)), p_sig[run_mode][m]);
        check("max_abs_err", longint'(bus.max_abs_err), p_max[run_mode][m]);
    end

    task automatic run_sweep(input int md, input int repulse, input longint e_cnt,
                             input longint e_abs, input longint e_sig, input longint e_max);
        int cyc;
        mode = md;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        check("first_done_low", longint'(bus.done), 0);
        check("first_busy", longint'(bus.busy), 1);
        check("first_op", longint'({bus.op_a, bus.op_b}), 0);
        cyc = 0;
        while (!bus.done && cyc < LAT + 20) begin
            bus.start = (cyc == repulse);
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        check("latency", longint'(cyc), longint'(LAT));
        check("final_err_count", longint'(bus.err_count), e_cnt);
        check("final_sum_abs", longint'(bus.sum_abs_err), e_abs);
        check("final_sum_signed", longint'($signed(bus.sum_signed_err)), e_sig);
        check("final_max_abs", longint'(bus.max_abs_err), e_max);
        repeat (3) @(posedge clk);
        #1 check("done_held", longint'(bus.done), 1);
    endtask

    initial begin
        bus.start = 1'b0;
        build_model();
        check("model_exact_cnt", p_cnt[0][NP], 0);
        check("model_zero_cnt", p_cnt[1][NP], 225);
        check("model_zero_abs", p_abs[1][NP], 14400);
        check("model_zero_sig", p_sig[1][NP], -14400);
        check("model_lsb_sig", p_sig[2][NP], 128);
        check("model_lsb_max", p_max[2][NP], 1);

        #1;
        check("rst_busy", longint'(bus.busy), 0);
        check("rst_done", longint'(bus.done), 0);
        check("rst_err_count", longint'(bus.err_count), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_sweep(0, -1, 0, 0, 0, 0);
        run_sweep(1, -1, 225, 14400, -14400, 225);
        run_sweep(2, -1, 256, 256, 128, 1);
        run_sweep(2, 50, 256, 256, 128, 1);

        // Abort a stuck-zero sweep at cycle 100 with a mid-cycle reset.
        mode = 1;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (100) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", longint'(bus.busy), 0);
        check("abort_done", longint'(bus.done), 0);
        check("abort_op", longint'({bus.op_a, bus.op_b}), 0);
        check("abort_err_count", longint'(bus.err_count), 0);
        check("abort_sum_abs", longint'(bus.sum_abs_err), 0);
        check("abort_sum_signed", longint'(bus.sum_signed_err), 0);
        check("abort_max_abs", longint'(bus.max_abs_err), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        run_sweep(0, -1, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
